// File: rtl/instr_exec_unit.sv
// Instruction execution unit: walks a run of instruction-register locations, executes
// each opcode (single-cycle ALU ops or a multi-cycle restoring divide) and hands results out.
module instr_exec_unit #(
  parameter int N_CYC_DIV = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic        [4:0]  first_addr,
  input  logic        [5:0]  count,
  output logic        [4:0]  read_pointer,
  input  logic        [3:0]  opc,
  input  logic signed [31:0] op_a,
  input  logic signed [31:0] op_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [63:0] res_data,
  output logic        [4:0]  res_addr,
  output logic        [3:0]  res_opc,
  output logic               res_err,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (N_CYC_DIV > 1) ? $clog2(N_CYC_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC_DIV - 1);

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    DIVIDE = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t             state_r;
  logic [3:0]         opc_r;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic [4:0]         addr_r;
  logic [5:0]         remaining_r;
  logic [31:0]        div_rem_r;
  logic [31:0]        div_quo_r;
  logic [31:0]        div_dsr_r;
  logic [CNT_W-1:0]   div_cnt_r;
  logic               q_neg_r;
  logic               r_neg_r;

  logic signed [63:0] a_ext_s;
  logic signed [63:0] b_ext_s;
  logic signed [63:0] exec_data_s;
  logic               exec_err_s;
  logic               exec_div_s;
  logic [31:0]        a_mag_s;
  logic [31:0]        b_mag_s;

  logic [32:0]        div_shift_s;
  logic               div_ge_s;
  logic [31:0]        div_rem_nxt_s;
  logic [31:0]        div_quo_nxt_s;
  logic [63:0]        quo_ext_s;
  logic [63:0]        rem_ext_s;
  logic [63:0]        div_result_s;

  // Single-cycle opcode evaluation on the latched operands
  always_comb begin
    a_ext_s     = {{32{a_r[31]}}, a_r};
    b_ext_s     = {{32{b_r[31]}}, b_r};
    a_mag_s     = a_r[31] ? (32'd0 - a_r) : a_r;
    b_mag_s     = b_r[31] ? (32'd0 - b_r) : b_r;
    exec_data_s = 64'sd0;
    exec_err_s  = 1'b0;
    exec_div_s  = 1'b0;
    case (opc_r)
      OP_ZERO:  exec_data_s = 64'sd0;
      OP_PASSA: exec_data_s = a_ext_s;
      OP_PASSB: exec_data_s = b_ext_s;
      OP_ADD:   exec_data_s = a_ext_s + b_ext_s;
      OP_SUB:   exec_data_s = a_ext_s - b_ext_s;
      OP_MULT:  exec_data_s = a_ext_s * b_ext_s;
      OP_DIV, OP_MOD: begin
        if (b_r == 32'd0) begin
          exec_err_s = 1'b1;
        end else begin
          exec_div_s = 1'b1;
        end
      end
      default:  exec_err_s = 1'b1;
    endcase
  end

  // One restoring-divide step plus sign correction of the would-be final values
  always_comb begin
    div_shift_s = {div_rem_r, div_quo_r[31]};
    div_ge_s    = (div_shift_s >= {1'b0, div_dsr_r});
    if (div_ge_s) begin
      div_rem_nxt_s = 32'(div_shift_s - {1'b0, div_dsr_r});
      div_quo_nxt_s = {div_quo_r[30:0], 1'b1};
    end else begin
      div_rem_nxt_s = div_shift_s[31:0];
      div_quo_nxt_s = {div_quo_r[30:0], 1'b0};
    end
    // Magnitudes are zero-extended first so -2^31 / -1 yields +2^31
    quo_ext_s = {32'd0, div_quo_nxt_s};
    rem_ext_s = {32'd0, div_rem_nxt_s};
    if (opc_r == OP_MOD) begin
      div_result_s = r_neg_r ? (64'd0 - rem_ext_s) : rem_ext_s;
    end else begin
      div_result_s = q_neg_r ? (64'd0 - quo_ext_s) : quo_ext_s;
    end
  end

  // Run-control FSM with registered result and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      read_pointer <= 5'd0;
      remaining_r  <= 6'd0;
      opc_r        <= 4'd0;
      a_r          <= 32'd0;
      b_r          <= 32'd0;
      addr_r       <= 5'd0;
      div_rem_r    <= 32'd0;
      div_quo_r    <= 32'd0;
      div_dsr_r    <= 32'd0;
      div_cnt_r    <= {CNT_W{1'b0}};
      q_neg_r      <= 1'b0;
      r_neg_r      <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= 64'sd0;
      res_addr     <= 5'd0;
      res_opc      <= 4'd0;
      res_err      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (count != 6'd0) begin
              read_pointer <= first_addr;
              remaining_r  <= count;
              busy         <= 1'b1;
              state_r      <= FETCH;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          opc_r   <= opc;
          a_r     <= op_a;
          b_r     <= op_b;
          addr_r  <= read_pointer;
          state_r <= EXEC;
        end
        EXEC: begin
          res_addr <= addr_r;
          res_opc  <= opc_r;
          if (exec_div_s) begin
            div_rem_r <= 32'd0;
            div_quo_r <= a_mag_s;
            div_dsr_r <= b_mag_s;
            div_cnt_r <= {CNT_W{1'b0}};
            q_neg_r   <= a_r[31] ^ b_r[31];
            r_neg_r   <= a_r[31];
            state_r   <= DIVIDE;
          end else begin
            res_data  <= exec_data_s;
            res_err   <= exec_err_s;
            res_valid <= 1'b1;
            state_r   <= OUTPUT;
          end
        end
        DIVIDE: begin
          div_rem_r <= div_rem_nxt_s;
          div_quo_r <= div_quo_nxt_s;
          if (div_cnt_r == CNT_LAST) begin
            res_data  <= div_result_s;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state_r   <= OUTPUT;
          end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (remaining_r > 6'd1) begin
              remaining_r  <= remaining_r - 6'd1;
              read_pointer <= read_pointer + 5'd1;
              state_r      <= FETCH;
            end else begin
              remaining_r <= 6'd0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state_r     <= IDLE;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
